// File: rtl/frv_mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   port_id_e : requester tag (PORT_I = instruction, PORT_D = data)
//   mem_req_t : request payload carried from a port to the memory
//   lock_e    : which port the selection is held on after an ungranted request
package frv_mem_arb_pkg;

  localparam int unsigned OUTSTANDING_DEF  = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned STRB_W           = DATA_W / 8;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_I    = 2'd1,
    LK_D    = 2'd2
  } lock_e;

  typedef struct packed {
    logic              wen;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
  } mem_req_t;

endpackage

// File: rtl/frv_arb_tag_fifo.sv
// In-order tag FIFO recording which port owns each outstanding transaction.
// Ports:
//   g_clk, g_reset : clock, asynchronous active-high reset
//   i_push, i_push_data : enqueue one tag (ignored while full, even with a pop)
//   i_pop          : dequeue the head tag (ignored while empty)
//   o_head         : tag at the head of the queue
//   o_full, o_empty: occupancy flags
module frv_arb_tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic g_clk,
  input  logic g_reset,
  input  logic i_push,
  input  logic i_push_data,
  input  logic i_pop,
  output logic o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  // Full check uses the pre-pop count: a pop never frees a slot for a same-cycle push.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/frv_mem_arbiter.sv
// Two-port (instruction / data) arbiter onto one shared memory port.
// Requests and responses pass through combinationally; an in-order tag FIFO
// routes each response back to the port that issued it.
// Ports:
//   g_clk, g_reset          : clock, asynchronous active-high reset
//   i_* / d_* req side      : req, wen, strb, wdata, addr in; gnt out
//   i_* / d_* response side : recv, error, rdata out; ack in
//   m_* request             : req, wen, strb, wdata, addr out; gnt in
//   m_* response            : recv, error, rdata in; ack out
module frv_mem_arbiter
  import frv_mem_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = OUTSTANDING_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              i_req,
  input  logic              d_req,
  input  logic              i_wen,
  input  logic              d_wen,
  input  logic [STRB_W-1:0] i_strb,
  input  logic [STRB_W-1:0] d_strb,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic              i_recv,
  output logic              d_recv,
  input  logic              i_ack,
  input  logic              d_ack,
  output logic              i_error,
  output logic              d_error,
  output logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wen,
  output logic [STRB_W-1:0] m_strb,
  output logic [DATA_W-1:0] m_wdata,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_gnt,
  input  logic              m_recv,
  input  logic              m_error,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              m_ack
);

  localparam int unsigned ST_W = $clog2(STARVE_LIMIT + 1);

  lock_e           r_lock;
  lock_e           w_lock_nxt;
  logic [ST_W-1:0] r_starve;
  logic            w_starved;
  logic            w_sel_valid;
  port_id_e        w_sel;
  logic            w_sel_req;
  logic            w_m_req;
  logic            w_accept;
  logic            w_full;
  logic            w_empty;
  logic            w_head;
  port_id_e        w_head_port;
  logic            w_head_is_i;
  logic            w_head_is_d;
  logic            w_pop;
  mem_req_t        w_i_bus;
  mem_req_t        w_d_bus;
  mem_req_t        w_m_bus;

  assign w_starved = (r_starve == ST_W'(STARVE_LIMIT));

  // Port selection: a pending lock wins, then a starved instruction port, then data.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = PORT_D;
    case (r_lock)
      LK_I: begin
        w_sel_valid = 1'b1;
        w_sel       = PORT_I;
      end
      LK_D: begin
        w_sel_valid = 1'b1;
        w_sel       = PORT_D;
      end
      default: begin
        if (i_req && w_starved) begin
          w_sel_valid = 1'b1;
          w_sel       = PORT_I;
        end else if (d_req) begin
          w_sel_valid = 1'b1;
          w_sel       = PORT_D;
        end else if (i_req) begin
          w_sel_valid = 1'b1;
          w_sel       = PORT_I;
        end
      end
    endcase
  end

  assign w_sel_req = w_sel_valid && ((w_sel == PORT_I) ? i_req : d_req);
  assign w_m_req   = !g_reset && w_sel_req && !w_full;
  assign w_accept  = w_m_req && m_gnt;

  assign w_i_bus = {i_wen, i_strb, i_wdata, i_addr};
  assign w_d_bus = {d_wen, d_strb, d_wdata, d_addr};
  assign w_m_bus = !w_m_req ? '0 : ((w_sel == PORT_I) ? w_i_bus : w_d_bus);

  assign m_req   = w_m_req;
  assign m_wen   = w_m_bus.wen;
  assign m_strb  = w_m_bus.strb;
  assign m_wdata = w_m_bus.wdata;
  assign m_addr  = w_m_bus.addr;
  assign i_gnt   = w_accept && (w_sel == PORT_I);
  assign d_gnt   = w_accept && (w_sel == PORT_D);

  // Lock state register.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_lock <= LK_NONE;
    end else begin
      r_lock <= w_lock_nxt;
    end
  end

  // An offered but ungranted request pins selection until the memory takes it.
  always_comb begin
    w_lock_nxt = r_lock;
    if (w_m_req && !m_gnt) begin
      w_lock_nxt = (w_sel == PORT_I) ? LK_I : LK_D;
    end else if (w_accept) begin
      w_lock_nxt = LK_NONE;
    end
  end

  // Counts data grants taken while the instruction port is waiting.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_starve <= '0;
    end else if (!i_req || (w_accept && (w_sel == PORT_I))) begin
      r_starve <= '0;
    end else if (w_accept && (w_sel == PORT_D) && !w_starved) begin
      r_starve <= r_starve + ST_W'(1);
    end
  end

  frv_arb_tag_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_tag_fifo (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .i_push     (w_accept),
    .i_push_data(1'(w_sel)),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Response routing to the owner of the oldest outstanding transaction.
  assign w_head_port = port_id_e'(w_head);
  assign w_head_is_i = !w_empty && (w_head_port == PORT_I);
  assign w_head_is_d = !w_empty && (w_head_port == PORT_D);

  assign m_ack   = (w_head_is_i && i_ack) || (w_head_is_d && d_ack);
  assign w_pop   = m_recv && m_ack;

  assign i_recv  = w_head_is_i && m_recv;
  assign d_recv  = w_head_is_d && m_recv;
  assign i_error = w_head_is_i && m_error;
  assign d_error = w_head_is_d && m_error;
  assign i_rdata = w_head_is_i ? m_rdata : '0;
  assign d_rdata = w_head_is_d ? m_rdata : '0;

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Bench for frv_mem_arbiter: directed scenarios followed by random traffic,
// all outputs compared each cycle against a queue-based transaction model.
module tb_frv_mem_arbiter;

  localparam int OUTST  = 4;
  localparam int STARVE = 4;

  logic        g_clk, g_reset;
  logic        i_req, d_req, i_wen, d_wen;
  logic [3:0]  i_strb, d_strb;
  logic [31:0] i_wdata, d_wdata, i_addr, d_addr;
  logic        i_gnt, d_gnt, i_recv, d_recv, i_ack, d_ack, i_error, d_error;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wen;
  logic [3:0]  m_strb;
  logic [31:0] m_wdata, m_addr;
  logic        m_gnt, m_recv, m_error, m_ack;
  logic [31:0] m_rdata;

  int n_checks;
  int n_errors;

  // Model: queue of owners in issue order, grants taken while i waits, held port.
  bit mq[$];
  int m_starve;
  int m_lock;

  frv_mem_arbiter #(.OUTSTANDING(OUTST), .STARVE_LIMIT(STARVE)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .i_req(i_req), .d_req(d_req), .i_wen(i_wen), .d_wen(d_wen),
    .i_strb(i_strb), .d_strb(d_strb), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_addr(i_addr), .d_addr(d_addr), .i_gnt(i_gnt), .d_gnt(d_gnt),
    .i_recv(i_recv), .d_recv(d_recv), .i_ack(i_ack), .d_ack(d_ack),
    .i_error(i_error), .d_error(d_error), .i_rdata(i_rdata), .d_rdata(d_rdata),
    .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata),
    .m_addr(m_addr), .m_gnt(m_gnt), .m_recv(m_recv), .m_error(m_error),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  // Compare every output with the model, then advance the model across the coming edge.
  task automatic cmp_model();
    int   sel;
    int   head;
    logic sreq, full, e_mreq, e_ack, push, pop;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;
    logic        e_wen;
    if (g_reset) begin
      mq.delete();
      m_starve = 0;
      m_lock   = -1;
    end
    if (m_lock >= 0)                     sel = m_lock;
    else if (i_req && m_starve == STARVE) sel = 0;
    else if (d_req)                      sel = 1;
    else if (i_req)                      sel = 0;
    else                                 sel = -1;
    sreq   = (sel == 0) ? i_req : ((sel == 1) ? d_req : 1'b0);
    full   = (mq.size() >= OUTST);
    e_mreq = !g_reset && sreq && !full;
    e_addr  = !e_mreq ? 32'h0 : ((sel == 1) ? d_addr  : i_addr);
    e_wdata = !e_mreq ? 32'h0 : ((sel == 1) ? d_wdata : i_wdata);
    e_strb  = !e_mreq ? 4'h0  : ((sel == 1) ? d_strb  : i_strb);
    e_wen   = !e_mreq ? 1'b0  : ((sel == 1) ? d_wen   : i_wen);
    head  = (mq.size() > 0) ? int'(mq[0]) : -1;
    e_ack = (head == 0 && i_ack) || (head == 1 && d_ack);

    chk1 ("m_req",   m_req,   e_mreq);
    chk32("m_addr",  m_addr,  e_addr);
    chk32("m_wdata", m_wdata, e_wdata);
    chk32("m_strb",  32'(m_strb), 32'(e_strb));
    chk1 ("m_wen",   m_wen,   e_wen);
    chk1 ("i_gnt",   i_gnt,   e_mreq && m_gnt && sel == 0);
    chk1 ("d_gnt",   d_gnt,   e_mreq && m_gnt && sel == 1);
    chk1 ("m_ack",   m_ack,   e_ack);
    chk1 ("i_recv",  i_recv,  head == 0 && m_recv);
    chk1 ("d_recv",  d_recv,  head == 1 && m_recv);
    chk1 ("i_error", i_error, head == 0 && m_error);
    chk1 ("d_error", d_error, head == 1 && m_error);
    chk32("i_rdata", i_rdata, (head == 0) ? m_rdata : 32'h0);
    chk32("d_rdata", d_rdata, (head == 1) ? m_rdata : 32'h0);

    pop  = m_recv && e_ack;
    push = e_mreq && m_gnt;
    if (pop) mq.delete(0);
    if (push) mq.push_back(sel == 1);
    if ((push && sel == 0) || !i_req) m_starve = 0;
    else if (push && sel == 1 && m_starve < STARVE) m_starve++;
    if (e_mreq && !m_gnt) m_lock = sel;
    else if (push)        m_lock = -1;
  endtask

  task automatic fin();
    cmp_model();
    tick();
  endtask

  task automatic drain();
    i_req = 0; d_req = 0; m_recv = 1; i_ack = 1; d_ack = 1; m_error = 0;
    for (int k = 0; k < 12 && mq.size() > 0; k++) begin
      m_rdata = $urandom;
      settle();
      fin();
    end
    m_recv = 0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_starve = 0; m_lock = -1; mq.delete();
    g_reset = 1;
    i_req = 1; d_req = 1; i_wen = 0; d_wen = 0; i_strb = 4'hF; d_strb = 4'hF;
    i_wdata = 32'h1111; d_wdata = 32'h2222; i_addr = 32'h100; d_addr = 32'h200;
    i_ack = 1; d_ack = 1; m_gnt = 1; m_recv = 1; m_error = 1; m_rdata = 32'hDEAD;
    tick();

    // Reset holds everything quiet even with live inputs.
    settle();
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_m_ack", m_ack, 1'b0);
    chk1("rst_d_recv", d_recv, 1'b0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    fin();
    g_reset = 0; i_req = 0; d_req = 0; m_recv = 0; m_error = 0;
    settle(); fin();

    // Starvation: four data grants, then the instruction port.
    i_req = 1; d_req = 1; m_gnt = 1; m_recv = 1; i_ack = 1; d_ack = 1;
    for (int c = 1; c <= 6; c++) begin
      settle();
      chk32("starve_addr", m_addr, (c == 5) ? 32'h100 : 32'h200);
      chk1("starve_dgnt", d_gnt, c != 5);
      chk1("starve_ignt", i_gnt, c == 5);
      fin();
    end
    drain();

    // Lock: ungranted data request stays selected after i_req rises.
    d_req = 1; m_gnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) i_req = 1;
      settle();
      chk32("lock_addr", m_addr, 32'h200);
      chk1("lock_ignt", i_gnt, 1'b0);
      fin();
    end
    m_gnt = 1;
    settle();
    chk1("lock_dgnt", d_gnt, 1'b1);
    chk1("lock_ignt2", i_gnt, 1'b0);
    fin();
    d_req = 0;
    settle();
    chk1("lock_i_after", i_gnt, 1'b1);
    fin();
    drain();

    // Full FIFO: no fifth request, no bypass on a same-cycle pop.
    i_req = 1; m_gnt = 1; m_recv = 0;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk1("fill_ignt", i_gnt, 1'b1);
      fin();
    end
    settle();
    chk1("full_mreq", m_req, 1'b0);
    chk1("full_ignt", i_gnt, 1'b0);
    fin();
    m_recv = 1; i_ack = 1;
    settle();
    chk1("full_nobypass", m_req, 1'b0);
    chk1("full_pop_ack", m_ack, 1'b1);
    fin();
    m_recv = 0;
    settle();
    chk1("full_reopen", m_req, 1'b1);
    fin();
    drain();

    // In-order routing: d then i.
    d_addr = 32'h40; d_req = 1; m_gnt = 1; i_ack = 0; d_ack = 0;
    settle(); fin();
    d_req = 0; i_req = 1;
    settle(); fin();
    i_req = 0; m_recv = 1; i_ack = 1; d_ack = 1; m_rdata = 32'hAAAA;
    settle();
    chk32("order_d_rdata", d_rdata, 32'hAAAA);
    chk1("order_i_recv0", i_recv, 1'b0);
    fin();
    m_rdata = 32'h5555;
    settle();
    chk32("order_i_rdata", i_rdata, 32'h5555);
    chk32("order_d_rdata0", d_rdata, 32'h0);
    fin();
    m_recv = 0;

    // Error response held until ack.
    d_req = 1;
    settle(); fin();
    d_req = 0; m_recv = 1; m_error = 1; d_ack = 0; i_ack = 1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) d_ack = 1;
      settle();
      chk1("err_d_error", d_error, 1'b1);
      chk1("err_m_ack", m_ack, c == 2);
      fin();
    end
    settle();
    chk1("err_popped", d_recv, 1'b0);
    fin();
    m_recv = 0; m_error = 0;

    // Reset mid-burst with three outstanding.
    d_req = 1; m_gnt = 1;
    for (int c = 0; c < 3; c++) begin
      settle(); fin();
    end
    g_reset = 1; i_req = 1; m_recv = 1; i_ack = 1; d_ack = 1; m_rdata = 32'hBEEF;
    settle();
    chk1("midrst_m_req", m_req, 1'b0);
    chk1("midrst_d_gnt", d_gnt, 1'b0);
    chk1("midrst_d_recv", d_recv, 1'b0);
    chk32("midrst_d_rdata", d_rdata, 32'h0);
    fin();
    g_reset = 0; i_req = 0; d_req = 0;
    settle();
    chk1("postrst_d_recv", d_recv, 1'b0);
    chk1("postrst_i_recv", i_recv, 1'b0);
    chk1("postrst_m_ack", m_ack, 1'b0);
    fin();
    m_recv = 0;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      g_reset = ($urandom_range(0, 149) == 0);
      i_req   = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      i_wen   = 1'($urandom);
      d_wen   = 1'($urandom);
      i_strb  = 4'($urandom);
      d_strb  = 4'($urandom);
      i_wdata = $urandom;
      d_wdata = $urandom;
      i_addr  = $urandom;
      d_addr  = $urandom;
      m_gnt   = ($urandom_range(0, 3) != 0);
      m_recv  = 1'($urandom);
      m_error = 1'($urandom);
      m_rdata = $urandom;
      i_ack   = ($urandom_range(0, 3) != 0);
      d_ack   = ($urandom_range(0, 3) != 0);
      settle();
      fin();
    end
    g_reset = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
